top_div_sdiv_25s_8ns_16_seq: RTL

- Sequential fixed-point divider; the inverse of the 16s x 8ns -> 25-bit multiply used in the MIMO datapath.
- Divides a signed 25-bit product-domain value by an unsigned 8-bit scale and recovers a signed 16-bit quotient plus remainder.
- Used in the K-best / channel-normalisation path wherever a scaled value must be de-scaled.
- Restoring radix-2 algorithm, one quotient bit per cycle, start/done handshake, pipeline-freeze `ce`.

---
 rtl/top_div_pkg.sv | 25 ++
 rtl/top_div_sdiv_sat_fix.sv | 37 +++
 rtl/top_div_sdiv_25s_8ns_16_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/top_div_pkg.sv
// Shared types and width constants for the sequential signed dividers.
package top_div_pkg;

    localparam int unsigned DIVIDEND_W = 25;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned QUOT_W     = 16;
    localparam int unsigned REM_W      = DIVISOR_W + 1;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    localparam logic signed [QUOT_W-1:0] QMAX = 16'sh7FFF;
    localparam logic signed [QUOT_W-1:0] QMIN = 16'sh8000;

    // Largest quotient magnitudes that fit the signed output for each sign.
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(32767);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(32768);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/top_div_sdiv_sat_fix.sv
// Sign application and saturation of an unsigned quotient/remainder pair.
module top_div_sdiv_sat_fix
    import top_div_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] quo_mag_i,
    input  logic [REM_W-1:0]      rem_mag_i,
    input  logic                  neg_i,
    input  logic                  div_zero_i,
    output logic [QUOT_W-1:0]     quotient_o,
    output logic [REM_W-1:0]      remainder_o,
    output logic                  ovf_o
);

    // Divide-by-zero forces full scale; otherwise negate for a negative
    // dividend and clamp to the signed 16-bit range.
    always_comb begin
        quotient_o  = quo_mag_i[QUOT_W-1:0];
        remainder_o = rem_mag_i;
        ovf_o       = 1'b0;
        if (div_zero_i) begin
            quotient_o  = neg_i ? QMIN : QMAX;
            remainder_o = '0;
        end else if (neg_i) begin
            remainder_o = -rem_mag_i;
            if (quo_mag_i > NEG_LIM) begin
                quotient_o = QMIN;
                ovf_o      = 1'b1;
            end else begin
                quotient_o = -quo_mag_i[QUOT_W-1:0];
            end
        end else if (quo_mag_i > POS_LIM) begin
            quotient_o = QMAX;
            ovf_o      = 1'b1;
        end
    end

endmodule

// File: rtl/top_div_sdiv_25s_8ns_16_seq.sv
// Restoring radix-2 divider: signed 25-bit / unsigned 8-bit -> saturated
// signed 16-bit quotient plus remainder, one quotient bit per enabled cycle.
module top_div_sdiv_25s_8ns_16_seq
    import top_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient,
    output logic [REM_W-1:0]      remainder,
    output logic                  div_zero,
    output logic                  ovf
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] mag_q, mag_d;    // dividend magnitude, becomes quotient
    logic [DIVISOR_W-1:0]  prem_q, prem_d;  // partial remainder, always < divisor
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic                  neg_q, neg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic [QUOT_W-1:0]     fix_quot;
    logic [REM_W-1:0]      fix_rem;
    logic                  fix_ovf;

    top_div_sdiv_sat_fix u_sat_fix (
        .quo_mag_i   (mag_q),
        .rem_mag_i   ({1'b0, prem_q}),
        .neg_i       (neg_q),
        .div_zero_i  (dvsr_q == '0),
        .quotient_o  (fix_quot),
        .remainder_o (fix_rem),
        .ovf_o       (fix_ovf)
    );

    // Next-state logic: capture, iterate the restoring step, then publish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        prem_d  = prem_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        shifted = {prem_q, mag_q[DIVIDEND_W-1]};
        trial   = {1'b0, shifted} - {2'b00, dvsr_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d   = dividend[DIVIDEND_W-1];
                    mag_d   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                    prem_d  = '0;
                    dvsr_d  = divisor;
                    cnt_d   = CNT_LAST;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_d = 1'b1;
                // Quotient bits shift in from the bottom as magnitude bits leave the top.
                mag_d  = {mag_q[DIVIDEND_W-2:0], ~trial[DIVISOR_W+1]};
                prem_d = trial[DIVISOR_W+1] ? shifted[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = fix_quot;
                rem_d   = fix_rem;
                ovf_d   = fix_ovf;
                dz_d    = (dvsr_q == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over ce, and ce=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            prem_q  <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            prem_q  <= prem_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign ovf       = ovf_q;

endmodule
